// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the shared-memory port arbiter.
// Contents:
//    PROC_COUNT    number of processors in the pool (default arbiter width)
//    PORT_IDX_W    width of a port index derived from PROC_COUNT
//    arb_state_t   arbiter FSM states
//    acc_t         kind of memory access granted
package mem_port_arbiter_pkg;

   localparam int PROC_COUNT = 4;
   localparam int PORT_IDX_W = $clog2(PROC_COUNT);

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef enum logic [0:0] {
      ACC_RD = 1'b0,
      ACC_WR = 1'b1
   } acc_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the processor pool and the memory arbiter.
// Signals:
//    i_req_rd / i_req_wr   per-port level requests (pool -> arbiter)
//    i_done                per-port transaction-complete pulse (pool -> arbiter)
//    o_grant_rd / o_grant_wr  one-hot-or-zero grants (arbiter -> pool)
//    o_sel, o_busy         current owner index and grant-outstanding flag
//    o_timeout_err         sticky per-port watchdog flags
// Modports: master = processor pool side, slave = arbiter side.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int PORT_COUNT = PROC_COUNT
);
   logic [PORT_COUNT-1:0]         i_req_rd;
   logic [PORT_COUNT-1:0]         i_req_wr;
   logic [PORT_COUNT-1:0]         i_done;
   logic [PORT_COUNT-1:0]         o_grant_rd;
   logic [PORT_COUNT-1:0]         o_grant_wr;
   logic [$clog2(PORT_COUNT)-1:0] o_sel;
   logic                          o_busy;
   logic [PORT_COUNT-1:0]         o_timeout_err;

   modport master (
      output i_req_rd, i_req_wr, i_done,
      input  o_grant_rd, o_grant_wr, o_sel, o_busy, o_timeout_err
   );

   modport slave (
      input  i_req_rd, i_req_wr, i_done,
      output o_grant_rd, o_grant_wr, o_sel, o_busy, o_timeout_err
   );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set bit of req scanning
// ptr+1, ptr+2, ... modulo N, so the port at ptr itself has lowest priority.
// Ports:
//    req    request vector
//    ptr    index of the most recently served port
//    idx    chosen index (0 when nothing is requested)
//    valid  at least one request is set
module mem_port_arbiter_rr_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int N = PROC_COUNT
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] idx,
   output logic                 valid
);
   localparam int IW = $clog2(N);

   int            cand_s;
   logic [IW-1:0] cand_idx_s;

   // Scan from farthest to nearest so the nearest requester after ptr wins.
   always_comb begin
      idx        = {IW{1'b0}};
      valid      = 1'b0;
      cand_s     = 0;
      cand_idx_s = {IW{1'b0}};
      for (int i = N; i >= 1; i--) begin
         cand_s     = (int'(ptr) + i) % N;
         cand_idx_s = IW'(cand_s);
         idx        = req[cand_idx_s] ? cand_idx_s : idx;
         valid      = valid | req[cand_idx_s];
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the single shared-memory access path.
// One port owns the path at a time for a read or a write; ownership ends on
// the owner's done pulse, on the owner dropping its granted request, or when
// the watchdog expires (which also sets that port's sticky error flag).
// Every release is followed by one idle cycle before the next arbitration.
// Ports:
//    i_clk   clock, rising edge
//    i_rst   synchronous active-high reset
//    bus     request/grant bundle (slave side), see mem_port_arbiter_if
// Parameters: PORT_COUNT (>=2), TIMEOUT (>=2), WR_FIRST (write wins on rd+wr).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int PORT_COUNT = PROC_COUNT,
   parameter int TIMEOUT    = 64,
   parameter bit WR_FIRST   = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   mem_port_arbiter_if.slave    bus
);
   localparam int IW    = $clog2(PORT_COUNT);
   localparam int CNT_W = $clog2(TIMEOUT);

   arb_state_t            state_r;
   logic [IW-1:0]         ptr_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [PORT_COUNT-1:0] grant_rd_r;
   logic [PORT_COUNT-1:0] grant_wr_r;
   logic [IW-1:0]         sel_r;
   logic                  busy_r;
   logic [PORT_COUNT-1:0] err_r;

   logic [PORT_COUNT-1:0] any_req_s;
   logic [IW-1:0]         pick_idx_s;
   logic                  pick_valid_s;
   acc_t                  pick_acc_s;
   logic [PORT_COUNT-1:0] pick_onehot_s;
   logic                  done_s;
   logic                  drop_s;
   logic                  tmo_s;

   assign any_req_s = bus.i_req_rd | bus.i_req_wr;

   mem_port_arbiter_rr_pick #(.N(PORT_COUNT)) u_pick (
      .req   (any_req_s),
      .ptr   (ptr_r),
      .idx   (pick_idx_s),
      .valid (pick_valid_s)
   );

   // Access type for the picked port; a dual request resolves by WR_FIRST.
   always_comb begin
      pick_acc_s    = ACC_RD;
      pick_onehot_s = {{(PORT_COUNT-1){1'b0}}, 1'b1} << pick_idx_s;
      if (bus.i_req_rd[pick_idx_s] && bus.i_req_wr[pick_idx_s]) begin
         pick_acc_s = WR_FIRST ? ACC_WR : ACC_RD;
      end else if (bus.i_req_wr[pick_idx_s]) begin
         pick_acc_s = ACC_WR;
      end else begin
         pick_acc_s = ACC_RD;
      end
   end

   // Release sources for the current owner; dropping the granted request counts as done.
   always_comb begin
      done_s = bus.i_done[sel_r];
      drop_s = (grant_rd_r[sel_r] & ~bus.i_req_rd[sel_r]) |
               (grant_wr_r[sel_r] & ~bus.i_req_wr[sel_r]);
      tmo_s  = (cnt_r == CNT_W'(TIMEOUT - 1));
   end

   // Arbiter FSM, watchdog counter and registered grant outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r    <= ARB_IDLE;
         ptr_r      <= IW'(PORT_COUNT - 1);
         cnt_r      <= {CNT_W{1'b0}};
         grant_rd_r <= {PORT_COUNT{1'b0}};
         grant_wr_r <= {PORT_COUNT{1'b0}};
         sel_r      <= {IW{1'b0}};
         busy_r     <= 1'b0;
         err_r      <= {PORT_COUNT{1'b0}};
      end else begin
         case (state_r)
            ARB_IDLE: begin
               if (pick_valid_s) begin
                  sel_r  <= pick_idx_s;
                  busy_r <= 1'b1;
                  cnt_r  <= {CNT_W{1'b0}};
                  if (pick_acc_s == ACC_WR) begin
                     grant_wr_r <= pick_onehot_s;
                  end else begin
                     grant_rd_r <= pick_onehot_s;
                  end
                  state_r <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (done_s || drop_s || tmo_s) begin
                  grant_rd_r <= {PORT_COUNT{1'b0}};
                  grant_wr_r <= {PORT_COUNT{1'b0}};
                  busy_r     <= 1'b0;
                  ptr_r      <= sel_r;
                  cnt_r      <= {CNT_W{1'b0}};
                  state_r    <= ARB_IDLE;
                  // A done (or drop) coinciding with expiry is a clean completion.
                  if (tmo_s && !done_s && !drop_s) begin
                     err_r[sel_r] <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r    <= ARB_IDLE;
               grant_rd_r <= {PORT_COUNT{1'b0}};
               grant_wr_r <= {PORT_COUNT{1'b0}};
               busy_r     <= 1'b0;
               cnt_r      <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign bus.o_grant_rd    = grant_rd_r;
   assign bus.o_grant_wr    = grant_wr_r;
   assign bus.o_sel         = sel_r;
   assign bus.o_busy        = busy_r;
   assign bus.o_timeout_err = err_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (PORT_COUNT=4, TIMEOUT=64, WR_FIRST=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mem_port_arbiter;
   logic clk_s;
   logic rst_s;
   int   n_cmp_r;
   int   n_err_r;

   mem_port_arbiter_if #(.PORT_COUNT(4)) bus ();

   mem_port_arbiter #(
      .PORT_COUNT (4),
      .TIMEOUT    (64),
      .WR_FIRST   (1'b1)
   ) dut (
      .i_clk (clk_s),
      .i_rst (rst_s),
      .bus   (bus.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk_s = 1'b0;
      forever #5 clk_s = ~clk_s;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp_r++;
      if (obs !== exp) begin
         n_err_r++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_s);
      #1;
   endtask

   task automatic do_reset();
      rst_s         = 1'b1;
      bus.i_req_rd  = 4'b0000;
      bus.i_req_wr  = 4'b0000;
      bus.i_done    = 4'b0000;
      tick();
      tick();
      rst_s = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rd"},   32'(bus.o_grant_rd), 32'h0);
      chk({tag, "_wr"},   32'(bus.o_grant_wr), 32'h0);
      chk({tag, "_busy"}, 32'(bus.o_busy),     32'h0);
   endtask

   // Directed test sequence.
   initial begin
      n_cmp_r = 0;
      n_err_r = 0;

      // Reset state
      do_reset();
      chk_idle("rst");
      chk("rst_err", 32'(bus.o_timeout_err), 32'h0);
      chk("rst_sel", 32'(bus.o_sel), 32'h0);

      // Single read grant and done release
      bus.i_req_rd = 4'b0001;
      tick();
      chk("t1_grd",  32'(bus.o_grant_rd), 32'h1);
      chk("t1_gwr",  32'(bus.o_grant_wr), 32'h0);
      chk("t1_sel",  32'(bus.o_sel), 32'h0);
      chk("t1_busy", 32'(bus.o_busy), 32'h1);
      bus.i_done = 4'b0001;
      tick();
      bus.i_done   = 4'b0000;
      bus.i_req_rd = 4'b0000;
      chk_idle("t1_rel");

      // Rotation with all ports writing; done 3 cycles after each grant
      do_reset();
      bus.i_req_wr = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t2_gwr%0d", k), 32'(bus.o_grant_wr), 32'(4'b0001 << (k % 4)));
         chk($sformatf("t2_sel%0d", k), 32'(bus.o_sel), 32'(k % 4));
         tick();
         tick();
         chk($sformatf("t2_hold%0d", k), 32'(bus.o_grant_wr), 32'(4'b0001 << (k % 4)));
         bus.i_done = 4'(4'b0001 << (k % 4));
         tick();
         bus.i_done = 4'b0000;
         chk($sformatf("t2_gap%0d", k), 32'(bus.o_busy), 32'h0);
         if (k < 4) begin
            tick();
         end else begin
            bus.i_req_wr = 4'b0000;
            tick();
         end
      end
      chk_idle("t2_end");

      // Dual request on port 2: write first, then read
      do_reset();
      bus.i_req_rd = 4'b0100;
      bus.i_req_wr = 4'b0100;
      tick();
      chk("t3_gwr", 32'(bus.o_grant_wr), 32'h4);
      chk("t3_grd", 32'(bus.o_grant_rd), 32'h0);
      bus.i_done = 4'b0100;
      tick();
      bus.i_done   = 4'b0000;
      bus.i_req_wr = 4'b0000;
      chk_idle("t3_gap");
      tick();
      chk("t3_grd2", 32'(bus.o_grant_rd), 32'h4);
      chk("t3_gwr2", 32'(bus.o_grant_wr), 32'h0);
      bus.i_done = 4'b0100;
      tick();
      bus.i_done   = 4'b0000;
      bus.i_req_rd = 4'b0000;
      chk_idle("t3_end");

      // Watchdog on port 1, then port 3 served
      do_reset();
      bus.i_req_rd = 4'b1010;
      tick();
      chk("t4_grd", 32'(bus.o_grant_rd), 32'h2);
      for (int c = 0; c < 63; c++) tick();
      chk("t4_hold63", 32'(bus.o_grant_rd), 32'h2);
      chk("t4_noerr",  32'(bus.o_timeout_err), 32'h0);
      tick();
      chk_idle("t4_drop");
      chk("t4_err", 32'(bus.o_timeout_err), 32'h2);
      tick();
      chk("t4_next", 32'(bus.o_grant_rd), 32'h8);
      chk("t4_sel3", 32'(bus.o_sel), 32'h3);
      bus.i_done = 4'b1000;
      tick();
      bus.i_done   = 4'b0000;
      bus.i_req_rd = 4'b0000;
      tick();
      chk("t4_errheld", 32'(bus.o_timeout_err), 32'h2);
      do_reset();
      chk("t4_errclr", 32'(bus.o_timeout_err), 32'h0);

      // Non-owner done ignored; owner drops request to release
      bus.i_req_rd = 4'b0001;
      tick();
      bus.i_done = 4'b1000;
      tick();
      bus.i_done = 4'b0000;
      chk("t5_held", 32'(bus.o_grant_rd), 32'h1);
      chk("t5_busy", 32'(bus.o_busy), 32'h1);
      bus.i_req_rd = 4'b0000;
      tick();
      chk_idle("t5_drop");

      // Reset mid-grant, then port 0 first
      do_reset();
      bus.i_req_rd = 4'b0100;
      tick();
      chk("t6_grd", 32'(bus.o_grant_rd), 32'h4);
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      chk_idle("t6_rst");
      bus.i_req_rd = 4'b0101;
      tick();
      chk("t6_first", 32'(bus.o_grant_rd), 32'h1);
      chk("t6_sel",   32'(bus.o_sel), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp_r, n_err_r);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter sharing the single shared-memory access path between the processors of the pool. Sits between the pool request outputs and the shared memory grant inputs. Grants one processor at a time, for either a read or a write transaction, and holds the grant until the owner signals completion. A watchdog forcibly reclaims the grant from a hung owner.

Parameters:
PORT_COUNT, 4, number of requesting processors (matches PROC_COUNT); must be >= 2.
TIMEOUT, 64, maximum cycles one grant may be held; must be >= 2.
WR_FIRST, 1, when a port requests read and write together: 1 grants write first, 0 grants read first.

Ports:
i_clk  in  1  clock, all logic on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_req_rd  in  PORT_COUNT  per-port read request, level, held until served.
i_req_wr  in  PORT_COUNT  per-port write request, level, held until served.
i_done  in  PORT_COUNT  per-port one-cycle transaction-complete pulse; ignored unless the port is the owner.
o_grant_rd  out  PORT_COUNT  one-hot-or-zero read grant, registered.
o_grant_wr  out  PORT_COUNT  one-hot-or-zero write grant, registered.
o_sel  out  $clog2(PORT_COUNT)  index of the current owner; valid while o_busy=1.
o_busy  out  1  a grant is outstanding.
o_timeout_err  out  PORT_COUNT  sticky per-port watchdog flag.

Behaviour:
- Reset: on a clock edge with i_rst=1:
  - all outputs go to 0;
  - the round-robin pointer goes to PORT_COUNT-1, so port 0 has first priority;
  - the watchdog counter goes to 0.
  - Reset mid-grant drops the grant at that edge with no done required.
- FSM state IDLE:
  - If any (i_req_rd|i_req_wr) is set, pick the first requesting port scanning ptr+1, ptr+2, ... modulo PORT_COUNT.
  - Register the grant: exactly one bit of o_grant_rd or o_grant_wr, set o_sel, o_busy=1, go to BUSY.
  - Latency: request seen at edge N gives grant visible after edge N, i.e. one cycle.
- Port requesting both rd and wr: the type is chosen by WR_FIRST. The other type stays pending and competes in a later round.
- FSM state BUSY:
  - The watchdog counter increments each cycle.
  - Release condition, any one of:
    - i_done[o_sel]=1;
    - the owner drops the request bit of its granted type (treated as done);
    - the counter reaches TIMEOUT-1 (sets o_timeout_err[o_sel]).
  - On release:
    - grants clear at the next edge; o_busy=0;
    - ptr<=o_sel; counter<=0;
    - return to IDLE.
  - A done and a timeout on the same cycle count as a normal done: no error flag.
- Turnaround: every release is followed by one IDLE cycle with no grant, then arbitration. Back-to-back owners therefore see a minimum 1-cycle gap.
- i_done from non-owners: ignored. Requests arriving during BUSY: queued implicitly by level, considered at the next IDLE.
- Fairness: with all ports requesting continuously, grants rotate 0,1,2,3,0,... A port waits at most PORT_COUNT-1 transactions.
- o_timeout_err bits are cleared only by reset.
- Invariants:
  - $onehot0(o_grant_rd|o_grant_wr);
  - o_grant_rd & o_grant_wr == 0;
  - o_busy == |(o_grant_rd|o_grant_wr).

Decomposition:
- Shared package holds:
  - the PROC_COUNT-derived constant for port index width;
  - an enum arb_state_t {ARB_IDLE, ARB_BUSY};
  - an enum acc_t {ACC_RD, ACC_WR}.
- One natural sub-module: rr_pick. It is a combinational round-robin priority picker: inputs are a request vector and the pointer; outputs are the index and a valid flag. It is reusable by the issuer for processor selection.
- Counter, FSM and grant registers stay in mem_port_arbiter.

Test Plan:
- Reset, then i_req_rd=4'b0001 -> grant_rd=4'b0001 one cycle later, o_sel=0. i_done[0] pulse -> grant cleared next cycle, o_busy=0.
- i_req_wr=4'b1111 held, each owner pulses done 3 cycles after its grant -> grant order 0,1,2,3,0 with exactly 1 idle cycle between grants.
- WR_FIRST=1, port 2 raises rd and wr together -> grant_wr=4'b0100 first. After done, the next round grants grant_rd=4'b0100.
- Port 1 granted and never sends done, TIMEOUT=64:
  - grant drops after 64 cycles;
  - o_timeout_err=4'b0010, held;
  - port 3 is served next;
  - assert i_rst -> err clears.
- Port 0 owner, i_done[3] pulsed -> ignored, grant held. Then port 0 drops i_req_rd -> release next edge.
- i_rst asserted while port 2 is granted -> all grants 0 after the edge. After reset, requests 4'b0101 -> port 0 is granted first.
